// File: rtl/core_ctrl_pkg.sv
// Shared control-path types and defaults for the core front-end sequencer.
package core_ctrl_pkg;

  // Sequencer state; encodings are visible on the state port.
  typedef enum logic [2:0] {
    StBoot   = 3'd0,
    StRun    = 3'd1,
    StDrain  = 3'd2,
    StHalted = 3'd3
  } state_e;

  localparam int unsigned DefaultBootCycles  = 4;
  localparam int unsigned DefaultDrainCycles = 3;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Pipeline-control bundle between the fetch sequencer and the rest of the core.
interface fetch_ctrl_if
  import core_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
);

  logic                 load_use_hazard;
  logic                 branch_taken;
  logic                 jump;
  logic                 halt_req;
  logic                 resume;
  logic                 pc_en;
  logic                 ifid_en;
  logic                 ifid_flush;
  logic                 idex_bubble;
  logic                 halted;
  state_e               state;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  // Sequencer side: consumes requests, drives pipeline enables.
  modport master (
    input  load_use_hazard, branch_taken, jump, halt_req, resume,
    output pc_en, ifid_en, ifid_flush, idex_bubble, halted, state,
    output stall_count, flush_count
  );

  // Pipeline / debug side: raises requests, obeys enables.
  modport slave (
    output load_use_hazard, branch_taken, jump, halt_req, resume,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, halted, state,
    input  stall_count, flush_count
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  // Increment on request unless already saturated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end sequencer: boot hold, load-use stall, redirect flush and halt/drain/resume.
module fetch_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES  = DefaultBootCycles,
  parameter int unsigned DRAIN_CYCLES = DefaultDrainCycles,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);

  localparam int unsigned BootW  = $clog2(BOOT_CYCLES + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  state_e               state_q;
  logic [BootW-1:0]     boot_cnt_q;
  logic [DrainW-1:0]    drain_cnt_q;
  logic                 halt_pending_q;
  logic                 halted_q;
  logic                 redirect;
  logic                 halt_now;
  logic                 stall_inc;
  logic                 flush_inc;
  logic                 pc_en;
  logic                 ifid_en;
  logic                 ifid_flush;
  logic                 idex_bubble;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  assign redirect = bus.branch_taken | bus.jump;
  // A halt_req in the current cycle counts as pending, so DRAIN follows immediately.
  assign halt_now = (halt_pending_q | bus.halt_req) & ~bus.load_use_hazard;

  // State, phase counters, pending halt and registered halted flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StBoot;
      boot_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      halt_pending_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: begin
          if (boot_cnt_q == BootW'(BOOT_CYCLES - 1)) begin
            state_q    <= StRun;
            boot_cnt_q <= '0;
          end else begin
            boot_cnt_q <= boot_cnt_q + BootW'(1);
          end
        end
        StRun: begin
          if (halt_now) begin
            state_q        <= StDrain;
            drain_cnt_q    <= '0;
            halt_pending_q <= 1'b0;
          end else if (bus.halt_req) begin
            halt_pending_q <= 1'b1;
          end
        end
        StDrain: begin
          if (drain_cnt_q == DrainW'(DRAIN_CYCLES - 1)) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DrainW'(1);
          end
        end
        StHalted: begin
          if (bus.resume) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StBoot;
        end
      endcase
    end
  end

  // Pipeline enables: hold-and-flush everywhere except RUN, where stall beats redirect.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    if (state_q == StRun) begin
      if (bus.load_use_hazard) begin
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
      end else if (redirect) begin
        pc_en       = 1'b1;
        idex_bubble = 1'b0;
      end else begin
        pc_en       = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
      end
    end
  end

  assign stall_inc = (state_q == StRun) & bus.load_use_hazard;
  assign flush_inc = (state_q == StRun) & ~bus.load_use_hazard & redirect;

  sat_counter #(
    .Width (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(
    .Width (CNT_WIDTH)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.halted      = halted_q;
  assign bus.state       = state_q;
  assign bus.stall_count = stall_cnt;
  assign bus.flush_count = flush_cnt;

endmodule
